// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcode constants, payload widths and beat-count helpers shared by the arbiter slice.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGICAL     = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] INTENT      = 3'd5;

  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam int BEAT_W = 8;

  // One 32-bit beat carries 4 bytes, so sizes above 4 bytes span 2^(size-2) beats.
  function automatic logic [BEAT_W-1:0] size_beats(input logic [3:0] size);
    if (size <= 4'd2) return BEAT_W'(1);
    return BEAT_W'(1) << (size - 4'd2);
  endfunction

  function automatic logic [BEAT_W-1:0] a_beats(input logic [2:0] opcode, input logic [3:0] size);
    if (opcode <= LOGICAL) return size_beats(size);
    return BEAT_W'(1);
  endfunction

  function automatic logic [BEAT_W-1:0] d_beats(input logic [2:0] opcode, input logic [3:0] size);
    if (opcode == ACK_DATA) return size_beats(size);
    return BEAT_W'(1);
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Tracks progress through a multi-beat message: loads on the first fire, counts down, flags the last beat.
module tl_beat_counter
  import tl_ul_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fire,
  input  logic [BEAT_W-1:0] beats,
  output logic              busy,
  output logic              last
);

  logic [BEAT_W-1:0] beats_left;

  // While idle the current beat is the first one, so its own length decides whether it is also the last.
  assign last = busy ? (beats_left == BEAT_W'(1)) : (beats <= BEAT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      beats_left <= '0;
    end else if (fire) begin
      if (busy) begin
        beats_left <= beats_left - BEAT_W'(1);
        if (beats_left == BEAT_W'(1)) busy <= 1'b0;
      end else if (beats > BEAT_W'(1)) begin
        busy       <= 1'b1;
        beats_left <= beats - BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tl_ul_a_arbiter_2to1.sv
// Two-master TL-UL arbiter: round-robin A channel locked across bursts, D routed back by source MSB.
// Define TL_ARB_INFLIGHT_LIMIT_EN to cap each master at MAX_INFLIGHT outstanding messages.
module tl_ul_a_arbiter_2to1
  import tl_ul_pkg::*;
#(
  parameter int SRC_W        = 2,
  parameter int ADDR_W       = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              m0_a_valid,
  output logic              m0_a_ready,
  input  logic [2:0]        m0_a_opcode,
  input  logic [2:0]        m0_a_param,
  input  logic [3:0]        m0_a_size,
  input  logic [SRC_W-1:0]  m0_a_source,
  input  logic [ADDR_W-1:0] m0_a_address,
  input  logic [MASK_W-1:0] m0_a_mask,
  input  logic [DATA_W-1:0] m0_a_data,
  input  logic              m0_a_corrupt,

  input  logic              m1_a_valid,
  output logic              m1_a_ready,
  input  logic [2:0]        m1_a_opcode,
  input  logic [2:0]        m1_a_param,
  input  logic [3:0]        m1_a_size,
  input  logic [SRC_W-1:0]  m1_a_source,
  input  logic [ADDR_W-1:0] m1_a_address,
  input  logic [MASK_W-1:0] m1_a_mask,
  input  logic [DATA_W-1:0] m1_a_data,
  input  logic              m1_a_corrupt,

  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [2:0]        out_a_opcode,
  output logic [2:0]        out_a_param,
  output logic [3:0]        out_a_size,
  output logic [SRC_W:0]    out_a_source,
  output logic [ADDR_W-1:0] out_a_address,
  output logic [MASK_W-1:0] out_a_mask,
  output logic [DATA_W-1:0] out_a_data,
  output logic              out_a_corrupt,

  input  logic              out_d_valid,
  output logic              out_d_ready,
  input  logic [2:0]        out_d_opcode,
  input  logic [1:0]        out_d_param,
  input  logic [3:0]        out_d_size,
  input  logic [SRC_W:0]    out_d_source,
  input  logic              out_d_sink,
  input  logic              out_d_denied,
  input  logic [DATA_W-1:0] out_d_data,
  input  logic              out_d_corrupt,

  output logic              m0_d_valid,
  input  logic              m0_d_ready,
  output logic [2:0]        m0_d_opcode,
  output logic [1:0]        m0_d_param,
  output logic [3:0]        m0_d_size,
  output logic [SRC_W-1:0]  m0_d_source,
  output logic              m0_d_sink,
  output logic              m0_d_denied,
  output logic [DATA_W-1:0] m0_d_data,
  output logic              m0_d_corrupt,

  output logic              m1_d_valid,
  input  logic              m1_d_ready,
  output logic [2:0]        m1_d_opcode,
  output logic [1:0]        m1_d_param,
  output logic [3:0]        m1_d_size,
  output logic [SRC_W-1:0]  m1_d_source,
  output logic              m1_d_sink,
  output logic              m1_d_denied,
  output logic [DATA_W-1:0] m1_d_data,
  output logic              m1_d_corrupt
);

  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 7) begin : g_bad_cfg
    $error("MAX_INFLIGHT must fit the 3-bit inflight counter (1..7)");
  end

  logic [1:0]        a_valid;
  logic [1:0]        a_avail;
  logic [1:0]        at_limit;
  logic              grant;
  logic              lock;
  logic              lock_idx;
  logic              rr_ptr;
  logic              a_fire;
  logic              a_last;
  logic [BEAT_W-1:0] a_beats_cur;

  assign a_valid = {m1_a_valid, m0_a_valid};
  assign a_avail = a_valid & ~at_limit;

  // Arbitration: a locked burst owns the port even while its master idles between beats.
  always_comb begin
    grant = rr_ptr;
    if (lock)                  grant = lock_idx;
    else if (a_avail[rr_ptr])  grant = rr_ptr;
    else if (a_avail[~rr_ptr]) grant = ~rr_ptr;
  end

  assign out_a_valid = lock ? a_valid[lock_idx] : (|a_avail);
  assign a_fire      = out_a_valid & out_a_ready;
  assign m0_a_ready  = out_a_ready & ~grant & (lock | a_avail[0]);
  assign m1_a_ready  = out_a_ready &  grant & (lock | a_avail[1]);

  assign out_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign out_a_param   = grant ? m1_a_param   : m0_a_param;
  assign out_a_size    = grant ? m1_a_size    : m0_a_size;
  assign out_a_source  = {grant, (grant ? m1_a_source : m0_a_source)};
  assign out_a_address = grant ? m1_a_address : m0_a_address;
  assign out_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign out_a_data    = grant ? m1_a_data    : m0_a_data;
  assign out_a_corrupt = grant ? m1_a_corrupt : m0_a_corrupt;

  assign a_beats_cur = a_beats(out_a_opcode, out_a_size);

  tl_beat_counter u_a_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .fire    (a_fire),
    .beats   (a_beats_cur),
    .busy    (lock),
    .last    (a_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_idx <= 1'b0;
      rr_ptr   <= 1'b0;
    end else if (a_fire) begin
      if (!lock) lock_idx <= grant;
      if (a_last) rr_ptr <= ~grant;
    end
  end

  // D return path: the extra source MSB selects the master, payload is broadcast.
  assign m0_d_valid  = out_d_valid & ~out_d_source[SRC_W];
  assign m1_d_valid  = out_d_valid &  out_d_source[SRC_W];
  assign out_d_ready = out_d_source[SRC_W] ? m1_d_ready : m0_d_ready;

  assign m0_d_opcode  = out_d_opcode;
  assign m0_d_param   = out_d_param;
  assign m0_d_size    = out_d_size;
  assign m0_d_source  = out_d_source[SRC_W-1:0];
  assign m0_d_sink    = out_d_sink;
  assign m0_d_denied  = out_d_denied;
  assign m0_d_data    = out_d_data;
  assign m0_d_corrupt = out_d_corrupt;

  assign m1_d_opcode  = out_d_opcode;
  assign m1_d_param   = out_d_param;
  assign m1_d_size    = out_d_size;
  assign m1_d_source  = out_d_source[SRC_W-1:0];
  assign m1_d_sink    = out_d_sink;
  assign m1_d_denied  = out_d_denied;
  assign m1_d_data    = out_d_data;
  assign m1_d_corrupt = out_d_corrupt;

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
  logic d_fire;
  logic d_last;
  logic d_busy;

  assign d_fire = out_d_valid & out_d_ready;

  tl_beat_counter u_d_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .fire    (d_fire),
    .beats   (d_beats(out_d_opcode, out_d_size)),
    .busy    (d_busy),
    .last    (d_last)
  );

  for (genvar i = 0; i < 2; i++) begin : g_inflight
    logic [2:0] count;
    logic       inc;
    logic       dec;

    assign inc = a_fire & a_last & (grant == 1'(i));
    // A stray response with nothing outstanding must not wrap the counter into a permanent stall.
    assign dec = d_fire & d_last & (out_d_source[SRC_W] == 1'(i)) & (count != 3'd0);
    assign at_limit[i] = (count == 3'(MAX_INFLIGHT));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          count <= 3'd0;
      else if (inc && !dec)  count <= count + 3'd1;
      else if (dec && !inc)  count <= count - 3'd1;
    end
  end
`else
  assign at_limit = 2'b00;
`endif

endmodule

// File: doc/tl_ul_a_arbiter_2to1.md
Name: tl_ul_a_arbiter_2to1

Overview:
- Two-master TileLink-UL arbiter in front of a single 32-bit TL-UL slave port, such as a peripheral crossbar leg or a memory port.
- A channel: round-robin arbitration, locked for the full duration of multi-beat Put/Atomic bursts.
- Upstream source IDs are extended with the master index, so D-channel responses steer back to the originating master without lookup state.
- Sits between the core/debug TL masters and the existing A/D channel passthrough stage.

Parameters:
- SRC_W, 2, per-master source ID width; output source is SRC_W+1 bits.
- ADDR_W, 32, address width.
- MAX_INFLIGHT, 4, per-master outstanding message limit (used only with the optional feature).

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mN_a_valid  in  1  master N (N=0,1) A valid.
- mN_a_ready  out  1  master N A ready.
- mN_a_opcode/param  in  3/3  A opcode, param.
- mN_a_size  in  4  log2 bytes.
- mN_a_source  in  SRC_W  source ID.
- mN_a_address  in  ADDR_W  byte address.
- mN_a_mask/data/corrupt  in  4/32/1  A payload.
- out_a_valid  out  1  slave-side A valid.
- out_a_ready  in  1  slave-side A ready.
- out_a_opcode/param/size  out  3/3/4  muxed A fields.
- out_a_source  out  SRC_W+1  {grant_idx, mN_a_source}.
- out_a_address/mask/data/corrupt  out  ADDR_W/4/32/1  muxed A payload.
- out_d_valid  in  1  slave D valid.
- out_d_ready  out  1  slave D ready.
- out_d_opcode/param/size  in  3/2/4  D header.
- out_d_source  in  SRC_W+1  D source.
- out_d_sink/denied/data/corrupt  in  1/1/32/1  D payload.
- mN_d_valid  out  1  master N D valid.
- mN_d_ready  in  1  master N D ready.
- mN_d_*  out  same as out_d_*  D fields; source is SRC_W bits (MSB stripped).

Behaviour:
- State: `lock` (1b), `lock_idx` (1b), `beats_left` (8b), `rr_ptr` (1b). Reset values: all 0, so master 0 has priority first.
- Beats per message:
  - Data-carrying opcodes (0 PutFull, 1 PutPartial, 2 Arithmetic, 3 Logical): size<=2 gives 1 beat; otherwise 1<<(size-2).
  - All other opcodes: 1 beat.
  - size>9 is illegal; the bench flags it and the RTL behaviour is don't-care.
- Unlocked: grant = rr_ptr master if valid, else the other master if valid.
  - out_a_valid = OR of the masters' valids.
  - Payload muxed by grant; only the granted master sees ready = out_a_ready; the other master's ready is 0.
- Locked: grant = lock_idx regardless of the other master's valid. If the granted master drops valid mid-burst, out_a_valid=0 and the lock holds.
- Fire (out_a_valid & out_a_ready):
  - First beat of a multi-beat message: set lock, lock_idx=grant, beats_left=beats-1.
  - Subsequent beats: beats_left decrements; the lock clears when a beat fires with beats_left==1.
- rr_ptr = ~grant on the last beat of every message, including single-beat messages.
- out_a_valid never depends combinationally on out_a_ready.
- D channel is purely combinational, no state:
  - mN_d_valid = out_d_valid & (out_d_source[SRC_W]==N).
  - out_d_ready = ready of the addressed master.
  - Fields are broadcast to both masters.
- Reset asserted mid-burst: the lock clears immediately. Upstream masters are reset in the same domain; a partial burst is not resumed.
- Simultaneous valids with rr_ptr=1: master 1 wins.

Optional Feature:
- Macro: TL_ARB_INFLIGHT_LIMIT_EN.
- With it defined:
  - Each master has a 3-bit inflight counter (reset 0).
  - +1 on the last A beat fire of that master's message.
  - -1 on the last D beat fire routed to that master. AccessAckData (opcode 1) is multi-beat by d_size using the same beat formula; other responses are 1 beat.
  - Simultaneous +1/-1: net unchanged.
  - A master with count==MAX_INFLIGHT is masked from starting a new message. An in-progress locked burst is never masked.
- Without it: no counters; inflight is unlimited.

Decomposition:
- Package tl_ul_pkg: opcode localparams (PUT_FULL=0, PUT_PARTIAL=1, ARITH=2, LOGICAL=3, GET=4, INTENT=5, ACK=0, ACK_DATA=1), beat-count function, data/mask width constants.
- One sub-module, tl_beat_counter: loads a count on the first beat, decrements per fire, flags `last`. Used for A-channel locking and for D-channel counting under the optional feature.

Test Plan:
- Both masters issue a Get (opcode 4, size 2) in the same cycle after reset, ready=1: m0 fires first with out_a_source=0b0xx, m1 next cycle with 0b1xx.
- m0 PutFull size 4 (4 beats) while m1 is valid throughout: out_a_source MSB=0 for 4 consecutive fires, then m1 is granted.
- m0 drops valid after beat 2 of a 4-beat burst for 3 cycles: out_a_valid=0 and m1_a_ready=0 for those cycles, then beats 3–4 complete from m0.
- D response with source=0b101, d_valid=1: only m1_d_valid=1, m1_d_source=0b01; m1_d_ready=0 gives out_d_ready=0.
- Assert reset_n=0 at beat 2 of 4: after release, m1 is granted immediately if m1 is valid and m0 is not.
- With TL_ARB_INFLIGHT_LIMIT_EN and MAX_INFLIGHT=2: m0 sends 2 Gets with no D response, so the third is stalled (m0_a_ready=0); after one AccessAckData the third fires.
